// File: rtl/nes_bus_pkg.sv
// nes_bus_pkg: shared NES bus types and register addresses for the OAM DMA controller
package nes_bus_pkg;
  typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} dma_state_t;
  localparam logic [15:0] REG_OAMDMA  = 16'h4014;
  localparam logic [15:0] REG_OAMDATA = 16'h2004;
endpackage

// File: rtl/oam_dma_ctrl.sv
// oam_dma_ctrl: $4014 sprite DMA sequencer; halts the CPU and copies page $XX00-$XXFF to $2004 (ports: clk, rst, cpu_ce/addr/dout/we, bus_din in; cpu_rdy, dma_active, bus_addr/dout/we out)
module oam_dma_ctrl
  import nes_bus_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR  = REG_OAMDMA,
  parameter logic [15:0] OAM_DATA_ADDR = REG_OAMDATA,
  parameter logic        ALIGN_EN      = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_ce,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_we,
  input  logic [7:0]  bus_din,
  output logic        cpu_rdy,
  output logic        dma_active,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_dout,
  output logic        bus_we
);
  dma_state_t  state_q, state_d;
  logic [7:0]  page_q, page_d, idx_q, idx_d, data_q, data_d;
  logic        parity_q;
  logic        cpu_rdy_q, cpu_rdy_d, dma_active_q, dma_active_d, bus_we_q, bus_we_d;
  logic [15:0] bus_addr_q, bus_addr_d;
  logic [7:0]  bus_dout_q, bus_dout_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      page_q       <= '0;
      idx_q        <= '0;
      data_q       <= '0;
      parity_q     <= 1'b0;
      cpu_rdy_q    <= 1'b1;
      dma_active_q <= 1'b0;
      bus_addr_q   <= '0;
      bus_dout_q   <= '0;
      bus_we_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      page_q       <= page_d;
      idx_q        <= idx_d;
      data_q       <= data_d;
      parity_q     <= parity_q ^ cpu_ce;
      cpu_rdy_q    <= cpu_rdy_d;
      dma_active_q <= dma_active_d;
      bus_addr_q   <= bus_addr_d;
      bus_dout_q   <= bus_dout_d;
      bus_we_q     <= bus_we_d;
    end
  end
  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    idx_d   = idx_q;
    data_d  = data_q;
    if (cpu_ce) begin
      case (state_q)
        IDLE: if (cpu_we && cpu_addr == DMA_REG_ADDR) begin
          state_d = HALT;
          page_d  = cpu_dout;
          idx_d   = '0;
        end
        // parity_q here is the parity of the HALT cycle; ALIGN pushes READ onto a get cycle
        HALT:  state_d = (ALIGN_EN && !parity_q) ? ALIGN : READ;
        ALIGN: state_d = READ;
        READ: begin
          data_d  = bus_din;
          state_d = WRITE;
        end
        WRITE: begin
          state_d = (idx_q == 8'hFF) ? IDLE : READ;
          idx_d   = (idx_q == 8'hFF) ? idx_q : idx_q + 8'd1;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  // Outputs are registered from the next state so they change together with state_q
  always_comb begin
    cpu_rdy_d    = state_d == IDLE;
    dma_active_d = state_d != IDLE;
    bus_we_d     = state_d == WRITE;
    bus_addr_d   = (state_d == READ) ? {page_d, idx_d} : (state_d == WRITE) ? OAM_DATA_ADDR : 16'h0000;
    bus_dout_d   = (state_d == WRITE) ? data_d : bus_dout_q;
  end
  assign cpu_rdy    = cpu_rdy_q;
  assign dma_active = dma_active_q;
  assign bus_addr   = bus_addr_q;
  assign bus_dout   = bus_dout_q;
  assign bus_we     = bus_we_q;
endmodule
